hazard_ctrl: RTL and testbench

Pipeline hazard controller for the RV32 core. It sits beside the decode-stage forwarding logic and sequences the front end.
- Detects load-use hazards that forwarding cannot cover.
- Holds the pipeline during multi-cycle EX operations (M/F units).
- Schedules flushes on taken branches and jumps.
- Drives stall, bubble and flush controls for the IF/ID/EX registers, and qualifies EX-stage forwarding while a bubble is in flight.

---
 rtl/control_pkg.sv | 11 +
 rtl/instructions_pkg.sv | 6 +
 rtl/hazard_perf_cnt.sv | 23 ++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// control_pkg: pipeline-control types shared by the hazard controller.
`default_nettype none
package control_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MC_BUSY  = 2'd2,
    FLUSH    = 2'd3
  } e_hazard_state;
endpackage
`default_nettype wire

// File: rtl/instructions_pkg.sv
// instructions_pkg: ISA-level constants shared across the RV32 core.
`default_nettype none
package instructions_pkg;
  localparam int RF_ADDR_W = 5;
endpackage
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: 32-bit saturating event counter (present only with HAZARD_PERF_CNT_EN).
`default_nettype none
`ifdef HAZARD_PERF_CNT_EN
module hazard_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] cnt_o
);
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;
endmodule
`endif
`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / multi-cycle / redirect sequencing for the RV32 front end.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
`default_nettype none
module hazard_ctrl
  import instructions_pkg::*;
  import control_pkg::*;
#(
  parameter int REG_W      = RF_ADDR_W,
  parameter int FLUSH_CYC  = 2,
  parameter int MC_MAX_CYC = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_rd_wr,
  input  logic             ex_is_load,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             redirect,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             flush_id,
  output logic             fwd_ex_valid,
  output logic             mc_timeout,
  output logic [1:0]       state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);
  localparam int          MC_W       = (MC_MAX_CYC > 1) ? $clog2(MC_MAX_CYC) : 1;
  localparam logic [MC_W-1:0] MC_LAST    = MC_W'(MC_MAX_CYC - 1);
  localparam logic [1:0]      FLUSH_LAST = 2'(FLUSH_CYC - 1);

  e_hazard_state   state_q, state_d;
  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [1:0]      flush_cnt_q, flush_cnt_d;
  logic            timeout_q, timeout_d;
  logic            redirect_taken;
  logic            load_use;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load && ex_rd_wr && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mc_cnt_q    <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mc_cnt_d       = mc_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    timeout_d      = timeout_q;
    redirect_taken = 1'b0;
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    bubble_ex      = 1'b0;
    flush_if       = 1'b0;
    flush_id       = 1'b0;
    fwd_ex_valid   = 1'b1;

    case (state_q)
      RUN: begin
        if (redirect) begin
          redirect_taken = 1'b1;
        end else if (ex_mc_start) begin
          state_d  = MC_BUSY;
          mc_cnt_d = '0;
        end else if (load_use) begin
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
          state_d   = LD_STALL;
        end
      end
      LD_STALL: begin
        fwd_ex_valid = 1'b0;
        state_d      = RUN;
        redirect_taken = redirect;
      end
      MC_BUSY: begin
        // EX is frozen here, so a redirect cannot be resolved and is ignored.
        stall_if = 1'b1;
        stall_id = 1'b1;
        mc_cnt_d = mc_cnt_q + MC_W'(1);
        if (ex_mc_done) begin
          state_d = RUN;
        end else if (mc_cnt_q == MC_LAST) begin
          timeout_d = 1'b1;
          state_d   = RUN;
        end
      end
      FLUSH: begin
        flush_if = (flush_cnt_q != 2'd0);
        if (flush_cnt_q != 2'd0) begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
        if (flush_cnt_q <= 2'd1) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (redirect_taken) begin
      flush_if    = 1'b1;
      flush_id    = 1'b1;
      flush_cnt_d = FLUSH_LAST;
      state_d     = (FLUSH_CYC > 1) ? FLUSH : RUN;
    end
  end

  assign mc_timeout = timeout_q;
  assign state_o    = state_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (stall_if),
    .cnt_o (perf_stall_cnt)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (redirect_taken),
    .cnt_o (perf_flush_cnt)
  );
`endif
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table plus hand-written multi-cycle sequences for hazard_ctrl.
`default_nettype none
module tb_hazard_ctrl;
  import control_pkg::*;

  localparam int REG_W      = 5;
  localparam int FLUSH_CYC  = 2;
  localparam int MC_MAX_CYC = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_rs1_used, id_rs2_used, ex_rd_wr, ex_is_load;
  logic             ex_mc_start, ex_mc_done, redirect;
  logic             stall_if, stall_id, bubble_ex, flush_if, flush_id;
  logic             fwd_ex_valid, mc_timeout;
  logic [1:0]       state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      perf_stall_cnt, perf_flush_cnt;
`endif

  hazard_ctrl #(
    .REG_W      (REG_W),
    .FLUSH_CYC  (FLUSH_CYC),
    .MC_MAX_CYC (MC_MAX_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd        (ex_rd),
    .ex_rd_wr     (ex_rd_wr),
    .ex_is_load   (ex_is_load),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_done   (ex_mc_done),
    .redirect     (redirect),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .bubble_ex    (bubble_ex),
    .flush_if     (flush_if),
    .flush_id     (flush_id),
    .fwd_ex_valid (fwd_ex_valid),
    .mc_timeout   (mc_timeout),
    .state_o      (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u;
    logic [4:0] rd;
    logic       rdwr;
    logic       ld;
    logic       mcs;
    logic       mcd;
    logic       redir;
    logic [8:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [8:0] got;
  assign got = {stall_if, stall_id, bubble_ex, flush_if, flush_id,
                fwd_ex_valid, mc_timeout, state_o};

  // Expected-output word: {stall_if, stall_id, bubble_ex, flush_if, flush_id, fwd, timeout, state}
  function automatic logic [8:0] mk_exp(input logic sif, input logic sid, input logic bub,
                                        input logic fif, input logic fid, input logic fwd,
                                        input logic tmo, input e_hazard_state st);
    return {sif, sid, bub, fif, fid, fwd, tmo, 2'(st)};
  endfunction

  function automatic vec_t mk_vec(input logic [4:0] rs1, input logic rs1u,
                                  input logic [4:0] rs2, input logic rs2u,
                                  input logic [4:0] rd, input logic rdwr, input logic ld,
                                  input logic mcs, input logic mcd, input logic redir,
                                  input logic [8:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u; v.rd = rd;
    v.rdwr = rdwr; v.ld = ld; v.mcs = mcs; v.mcd = mcd; v.redir = redir; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_rs1 = v.rs1; id_rs1_used = v.rs1u; id_rs2 = v.rs2; id_rs2_used = v.rs2u;
    ex_rd = v.rd; ex_rd_wr = v.rdwr; ex_is_load = v.ld;
    ex_mc_start = v.mcs; ex_mc_done = v.mcd; redirect = v.redir;
  endtask

  task automatic drive_ctl(input logic mcs, input logic mcd, input logic redir);
    id_rs1 = '0; id_rs1_used = 1'b0; id_rs2 = '0; id_rs2_used = 1'b0;
    ex_rd = '0; ex_rd_wr = 1'b0; ex_is_load = 1'b0;
    ex_mc_start = mcs; ex_mc_done = mcd; redirect = redir;
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, act, exp);
    end
  endtask

  vec_t       tbl[19];
  logic [8:0] idle_e, busy_e;

  initial begin
    idle_e = mk_exp(0, 0, 0, 0, 0, 1, 0, RUN);
    busy_e = mk_exp(1, 1, 0, 0, 0, 1, 0, MC_BUSY);

    tbl[0]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, idle_e);
    tbl[1]  = mk_vec(5, 1, 9, 1, 5, 1, 1, 0, 0, 0, mk_exp(1, 0, 1, 0, 0, 1, 0, RUN));
    tbl[2]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk_exp(0, 0, 0, 0, 0, 0, 0, LD_STALL));
    tbl[3]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, idle_e);
    tbl[4]  = mk_vec(3, 1, 0, 1, 0, 1, 1, 0, 0, 0, idle_e);
    tbl[5]  = mk_vec(3, 1, 7, 1, 7, 1, 1, 0, 0, 0, mk_exp(1, 0, 1, 0, 0, 1, 0, RUN));
    tbl[6]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, mk_exp(0, 0, 0, 1, 1, 0, 0, LD_STALL));
    tbl[7]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk_exp(0, 0, 0, 1, 0, 1, 0, FLUSH));
    tbl[8]  = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, idle_e);
    tbl[9]  = mk_vec(5, 1, 0, 0, 5, 0, 1, 0, 0, 0, idle_e);
    tbl[10] = mk_vec(5, 0, 0, 0, 5, 1, 1, 0, 0, 0, idle_e);
    tbl[11] = mk_vec(5, 1, 0, 0, 5, 1, 0, 0, 0, 0, idle_e);
    tbl[12] = mk_vec(5, 1, 0, 0, 5, 1, 1, 0, 0, 1, mk_exp(0, 0, 0, 1, 1, 1, 0, RUN));
    tbl[13] = mk_vec(5, 1, 0, 0, 5, 1, 1, 0, 0, 0, mk_exp(0, 0, 0, 1, 0, 1, 0, FLUSH));
    tbl[14] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, idle_e);
    tbl[15] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, idle_e);
    tbl[16] = mk_vec(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, mk_exp(0, 0, 0, 1, 1, 1, 0, RUN));
    tbl[17] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mk_exp(0, 0, 0, 1, 0, 1, 0, FLUSH));
    tbl[18] = mk_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, idle_e);

    rst = 1'b1;
    drive_ctl(0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset", idle_e);
`ifdef HAZARD_PERF_CNT_EN
    check32("perf_stall_reset", perf_stall_cnt, 32'd0);
    check32("perf_flush_reset", perf_flush_cnt, 32'd0);
`endif

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i]);
      #1 check($sformatf("vec%0d", i), tbl[i].exp);
      @(negedge clk);
    end

`ifdef HAZARD_PERF_CNT_EN
    check32("perf_stall_tbl", perf_stall_cnt, 32'd2);
    check32("perf_flush_tbl", perf_flush_cnt, 32'd3);
`endif

    // Multi-cycle op, done in the 6th busy cycle; a redirect mid-op is ignored.
    drive_ctl(1, 0, 0);
    #1 check("mc_start", idle_e);
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      drive_ctl(0, k == 5, k == 2);
      #1 check($sformatf("mc_busy%0d", k), busy_e);
      @(negedge clk);
    end
    drive_ctl(0, 0, 0);
    #1 check("mc_after", idle_e);
    @(negedge clk);

    // Done arriving exactly on the last watchdog cycle must not time out.
    drive_ctl(1, 0, 0);
    @(negedge clk);
    for (int k = 0; k < MC_MAX_CYC; k++) begin
      drive_ctl(0, k == MC_MAX_CYC - 1, 0);
      #1 check($sformatf("mc_edge%0d", k), busy_e);
      @(negedge clk);
    end
    drive_ctl(0, 0, 0);
    #1 check("mc_edge_after", idle_e);
    @(negedge clk);

    // Watchdog: no done, stall for MC_MAX_CYC cycles then sticky timeout.
    drive_ctl(1, 0, 0);
    @(negedge clk);
    for (int k = 0; k < MC_MAX_CYC; k++) begin
      drive_ctl(0, 0, 0);
      #1 check($sformatf("wdog_busy%0d", k), busy_e);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("wdog_hold%0d", k), mk_exp(0, 0, 0, 0, 0, 1, 1, RUN));
      @(negedge clk);
    end

    // Reset in the middle of a multi-cycle op.
    drive_ctl(1, 0, 0);
    @(negedge clk);
    drive_ctl(0, 0, 0);
    #1 check("rst_pre", mk_exp(1, 1, 0, 0, 0, 1, 1, MC_BUSY));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_mid", idle_e);
`ifdef HAZARD_PERF_CNT_EN
    check32("perf_stall_rst", perf_stall_cnt, 32'd0);
    check32("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif
    @(negedge clk);
    #1 check("rst_after", idle_e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got=running want=finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
